// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver datapath and its control FSM.
// Contents:
//   MIN_PRESCALE   - smallest oversampling ratio the timing logic will use
//   BIT_CNT_MAX    - saturation value of the bit index counter
//   START_BIT, PAR_BIT, STOP_BIT_NOPAR, STOP_BIT_PAR - frame bit indices
//   majority3()    - 2-of-3 vote used to de-glitch each received bit
package uart_rx_pkg;

    localparam int MIN_PRESCALE   = 8;
    localparam int BIT_CNT_MAX    = 15;

    localparam int START_BIT      = 0;
    localparam int PAR_BIT        = 9;
    localparam int STOP_BIT_NOPAR = 9;
    localparam int STOP_BIT_PAR   = 10;

    // Returns the value held by at least two of the three samples.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling edge counter and bit index counter for the UART receiver.
// The requested prescale is clamped to at least MIN_PRESCALE; the counters
// clear whenever the enable is low.
// Ports:
//   clk        - oversampling clock
//   rst        - synchronous active-high reset
//   en         - count enable (low clears both counters)
//   prescale   - requested oversampling ratio
//   edge_count - edge index within the current bit (registered)
//   bit_count  - index of the current bit, saturating (registered)
//   mid        - half of the effective prescale, the bit-centre edge index
module uart_rx_edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 6,
    parameter int BIT_CNT_WIDTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic [PRESCALE_WIDTH-1:0] edge_count,
    output logic [BIT_CNT_WIDTH-1:0]  bit_count,
    output logic [PRESCALE_WIDTH-1:0] mid
);

    logic [PRESCALE_WIDTH-1:0] p_eff_s;
    logic [PRESCALE_WIDTH-1:0] last_edge_s;

    // Clamp the prescale and derive the wrap point and bit centre.
    always_comb begin
        p_eff_s     = prescale;
        if (prescale < PRESCALE_WIDTH'(MIN_PRESCALE)) begin
            p_eff_s = PRESCALE_WIDTH'(MIN_PRESCALE);
        end else begin
            p_eff_s = prescale;
        end
        last_edge_s = p_eff_s - PRESCALE_WIDTH'(1);
        mid         = p_eff_s >> 1;
    end

    // Edge counter wraps at P-1 and advances the saturating bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_count <= '0;
            bit_count  <= '0;
        end else if (!en) begin
            edge_count <= '0;
            bit_count  <= '0;
        end else if (edge_count == last_edge_s) begin
            edge_count <= '0;
            if (bit_count != BIT_CNT_WIDTH'(BIT_CNT_MAX)) begin
                bit_count <= bit_count + BIT_CNT_WIDTH'(1);
            end else begin
                bit_count <= bit_count;
            end
        end else begin
            edge_count <= edge_count + PRESCALE_WIDTH'(1);
            bit_count  <= bit_count;
        end
    end

endmodule

// File: rtl/uart_rx_sample_unit.sv
// UART receiver oversampling and data-recovery stage.
// Counts oversampling edges and bits, takes a 3-sample majority vote around
// each bit centre (edges mid-1, mid, mid+1) and flags a start bit that votes 1.
// Ports:
//   CLK          - oversampling clock
//   RST          - synchronous active-high reset
//   RX_IN        - synchronised serial line, idle high
//   Prescale     - oversampling ratio (values below 8 are treated as 8)
//   edge_bit_en  - counter enable from the FSM
//   dat_samp_en  - sampler enable from the FSM
//   strt_chk_en  - start-bit check enable from the FSM
//   edge_count   - edge index within the current bit
//   bit_count    - current bit index, 0 = start bit, saturates at 15
//   sampled_bit  - majority-voted bit value
//   sample_valid - one-cycle pulse when sampled_bit updates
//   strt_glitch  - start bit voted as 1
module uart_rx_sample_unit
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 6,
    parameter int BIT_CNT_WIDTH  = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      edge_bit_en,
    input  logic                      dat_samp_en,
    input  logic                      strt_chk_en,
    output logic [PRESCALE_WIDTH-1:0] edge_count,
    output logic [BIT_CNT_WIDTH-1:0]  bit_count,
    output logic                      sampled_bit,
    output logic                      sample_valid,
    output logic                      strt_glitch
);

    logic [PRESCALE_WIDTH-1:0] mid_s;
    logic                      s0_r;
    logic                      s1_r;
    logic                      at_s0_s;
    logic                      at_s1_s;
    logic                      at_vote_s;
    logic                      vote_s;
    logic                      glitch_set_s;

    uart_rx_edge_bit_counter #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH),
        .BIT_CNT_WIDTH  (BIT_CNT_WIDTH)
    ) u_counter (
        .clk        (CLK),
        .rst        (RST),
        .en         (edge_bit_en),
        .prescale   (Prescale),
        .edge_count (edge_count),
        .bit_count  (bit_count),
        .mid        (mid_s)
    );

    // Decode the three sampling edges around the bit centre and form the vote.
    always_comb begin
        at_s0_s      = (edge_count == (mid_s - PRESCALE_WIDTH'(1)));
        at_s1_s      = (edge_count == mid_s);
        at_vote_s    = (edge_count == (mid_s + PRESCALE_WIDTH'(1)));
        vote_s       = majority3(s0_r, s1_r, RX_IN);
        glitch_set_s = 1'b0;
        if (strt_chk_en && dat_samp_en && at_vote_s &&
            (bit_count == BIT_CNT_WIDTH'(START_BIT))) begin
            glitch_set_s = vote_s;
        end else begin
            glitch_set_s = 1'b0;
        end
    end

    // Sample capture and vote; a dropped edge_bit_en throws away partial samples
    // so the next vote is built only from freshly captured values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s0_r         <= 1'b1;
            s1_r         <= 1'b1;
            sampled_bit  <= 1'b1;
            sample_valid <= 1'b0;
        end else if (!edge_bit_en) begin
            s0_r         <= 1'b1;
            s1_r         <= 1'b1;
            sampled_bit  <= sampled_bit;
            sample_valid <= 1'b0;
        end else if (dat_samp_en) begin
            sample_valid <= 1'b0;
            if (at_s0_s) begin
                s0_r <= RX_IN;
            end else begin
                s0_r <= s0_r;
            end
            if (at_s1_s) begin
                s1_r <= RX_IN;
            end else begin
                s1_r <= s1_r;
            end
            if (at_vote_s) begin
                sampled_bit  <= vote_s;
                sample_valid <= 1'b1;
            end else begin
                sampled_bit  <= sampled_bit;
            end
        end else begin
            s0_r         <= s0_r;
            s1_r         <= s1_r;
            sampled_bit  <= sampled_bit;
            sample_valid <= 1'b0;
        end
    end

    // Start-glitch flag: set with the start-bit vote, held while counting,
    // cleared once counting stops (clear takes priority).
    always_ff @(posedge CLK) begin
        if (RST) begin
            strt_glitch <= 1'b0;
        end else if (!edge_bit_en) begin
            strt_glitch <= 1'b0;
        end else if (glitch_set_s) begin
            strt_glitch <= 1'b1;
        end else begin
            strt_glitch <= strt_glitch;
        end
    end

endmodule

// File: doc/uart_rx_sample_unit.md
Name: uart_rx_sample_unit

Overview:
- Oversampling timing and data-recovery stage of the UART receiver. It sits directly upstream of the receiver control FSM.
- Counts oversampling edges and bit periods, and produces the edge_count and bit_count the FSM decodes.
- Takes a 3-sample majority vote around each bit centre to produce a clean sampled bit for the deserializer, parity checker and stop checker.
- Flags a start-bit glitch so the FSM can abort back to idle.

Parameters:
- PRESCALE_WIDTH, 6, width of the Prescale input and edge_count output.
- BIT_CNT_WIDTH, 4, width of bit_count; covers start + 8 data + parity + stop = 11 bits.

Ports:
- CLK  input  1  receiver oversampling clock (single clock domain).
- RST  input  1  synchronous, active-high reset.
- RX_IN  input  1  serial line, already synchronised to CLK upstream; idle = 1.
- Prescale  input  PRESCALE_WIDTH  oversampling ratio; legal values 8, 16, 32.
- edge_bit_en  input  1  counter enable from the FSM.
- dat_samp_en  input  1  sampler enable from the FSM.
- strt_chk_en  input  1  start-check enable from the FSM.
- edge_count  output  PRESCALE_WIDTH  oversampling edge index within the current bit.
- bit_count  output  BIT_CNT_WIDTH  index of the current bit; 0 = start bit.
- sampled_bit  output  1  majority-voted value of the current bit.
- sample_valid  output  1  one-cycle pulse when sampled_bit is updated.
- strt_glitch  output  1  start bit sampled as 1.

Behaviour:
- Reset (RST=1 at a rising CLK edge):
  - edge_count=0, bit_count=0.
  - sampled_bit=1, sample_valid=0, strt_glitch=0.
  - Internal samples s0 and s1 = 1.
  - Reset mid-frame aborts immediately; there is no residual state.
- Effective prescale P:
  - P = Prescale when Prescale >= 8.
  - P = 8 when Prescale < 8 (clamped; this covers 0).
  - Non-power-of-two values >= 8 are used as-is.
  - mid = P >> 1, computed as an unsigned truncating shift.
- Edge/bit counter:
  - edge_bit_en=0: edge_count and bit_count clear to 0 on the next edge.
  - edge_bit_en=1 and edge_count != P-1: edge_count increments.
  - edge_bit_en=1 and edge_count == P-1: edge_count wraps to 0 and bit_count increments.
  - bit_count saturates at 15 and never wraps to 0.
- Sampler (all actions only when dat_samp_en=1):
  - edge_count == mid-1: s0 <= RX_IN.
  - edge_count == mid: s1 <= RX_IN.
  - edge_count == mid+1: sampled_bit <= majority(s0, s1, RX_IN), and sample_valid <= 1 for exactly one cycle.
  - sampled_bit and sample_valid are therefore visible while edge_count == mid+2. Latency is 1 cycle after the third sample.
  - dat_samp_en=0: s0, s1 and sampled_bit hold their values; sample_valid=0.
  - If edge_bit_en drops between samples, the partial vote is discarded. The next vote uses only freshly captured s0 and s1.
- Glitch detector:
  - Set: when strt_chk_en=1, bit_count==0 and the vote at edge mid+1 evaluates to 1, strt_glitch <= 1 on that same edge, aligned with sample_valid.
  - Hold: stays 1 while edge_bit_en=1.
  - Clear: goes to 0 on the edge after edge_bit_en=0.
  - If the set and clear conditions occur in the same cycle, clear wins.
- Simultaneous edge wrap and sample: not possible, since mid+1 < P-1 for all P >= 8.
- All outputs are registered; there is no combinational path from input to output.

Decomposition:
- Shared package uart_rx_pkg:
  - localparams MIN_PRESCALE=8 and BIT_CNT_MAX=15.
  - Bit-index constants START_BIT=0, PAR_BIT=9, STOP_BIT_NOPAR=9, STOP_BIT_PAR=10, for use by this block and the FSM.
- One sub-module, uart_rx_edge_bit_counter:
  - Contains the clamp and the edge/bit counters.
  - Outputs edge_count, bit_count and mid.
- The sampler and glitch logic stay in the top.

Test Plan:
- Reset behaviour: RST=1 for 3 cycles mid-frame (edge_count=5, bit_count=3) -> all counters 0, sampled_bit=1, strt_glitch=0 on the next edge.
- Counter wrap: Prescale=8, edge_bit_en=1 for 88 cycles -> edge_count cycles 0..7, bit_count steps 0..10 and reaches 11 at cycle 88. Then hold edge_bit_en for 40 more bits -> bit_count saturates at 15.
- Majority vote: Prescale=16, RX_IN=0 at edges 7 and 9 with a 1-glitch at edge 8 -> sampled_bit=0 and sample_valid pulses at edge_count=10. Pattern 1,0,1 -> sampled_bit=1.
- Start glitch: Prescale=8, strt_chk_en=1, RX_IN=0 for 2 cycles then 1 -> strt_glitch=1 visible at edge_count=6, bit_count=0. Drop edge_bit_en -> strt_glitch=0 the next cycle.
- Prescale clamp and full frame: Prescale=0 -> behaves as P=8. Then Prescale=32 with byte 0xA5 LSB-first, parity bit and stop bit -> 11 sample_valid pulses, each at edge_count=18, with sampled_bit sequence 0,1,0,1,0,0,1,0,1,0,1.
